// File: rtl/dsi_segment_buffer.sv
// Ring of segment banks between a pixel producer and a DSI reader.
// Latency: rd_data one cycle after rd_en; fill_cnt/dsi_start update on the edge after the cause.
// Backpressure: wr_ready drops while the current write bank is full; writes then are dropped and flagged.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   wr_en, wr_data, wr_ready   pixel write side; a write lands only while wr_ready is high
//   rd_en, rd_addr, rd_data    random-access read of the current read bank (registered data)
//   rd_done                    consumer releases the current read bank
//   seg_ready, dsi_start       at least one full bank / one-cycle kick for the DSI transfer
//   rd_bank, fill_cnt          read bank index and number of full banks
//   overflow, underflow        sticky error flags (dropped write / release with nothing full)
module dsi_segment_buffer #(
  parameter int DATA_W    = 16,
  parameter int SEG_DEPTH = 1920,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic              seg_ready,
  output logic              dsi_start,
  output logic [1:0]        rd_bank,
  output logic [2:0]        fill_cnt,
  output logic              overflow,
  output logic              underflow
);

  localparam int MEM_DEPTH = NUM_BANKS * SEG_DEPTH;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEG_DEPTH - 1);
  localparam logic [1:0]        LAST_BANK = 2'(NUM_BANKS - 1);

  // Flat storage: bank b occupies [b*SEG_DEPTH, (b+1)*SEG_DEPTH).
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [1:0]           wbank;
  logic [1:0]           rbank;
  logic [ADDR_W-1:0]    waddr;
  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] full_next;
  logic [2:0]           cnt_next;

  logic wfull;
  logic rfull;
  logic wr_accept;
  logic seg_done;
  logic rd_pop;
  logic rd_in_range;
  logic start_evt;

  logic [MEM_AW-1:0] widx;
  logic [MEM_AW-1:0] ridx;

  function automatic logic [1:0] next_bank(input logic [1:0] b);
    return (b == LAST_BANK) ? 2'd0 : b + 2'd1;
  endfunction

  // Bank pointers are 2 bits wide regardless of NUM_BANKS, so the flag
  // lookups are done as explicit muxes rather than variable bit-selects.
  always_comb begin
    wfull = 1'b0;
    rfull = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (wbank == 2'(i)) wfull = full[i];
      if (rbank == 2'(i)) rfull = full[i];
    end
  end

  assign wr_ready    = !wfull;
  assign wr_accept   = wr_en && !wfull;
  assign seg_done    = wr_accept && (waddr == LAST_ADDR);
  assign rd_pop      = rd_done && rfull;
  assign rd_in_range = (rd_addr <= LAST_ADDR);

  // A completing write and a release never target the same bank: the write
  // bank is not full, while a valid release needs the read bank full.
  always_comb begin
    full_next = full;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (seg_done && (wbank == 2'(i))) full_next[i] = 1'b1;
      if (rd_pop   && (rbank == 2'(i))) full_next[i] = 1'b0;
    end
  end

  always_comb begin
    cnt_next = 3'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cnt_next = cnt_next + 3'(full_next[i]);
    end
  end

  // Kick the DSI engine when the first segment arrives in an empty ring, or
  // when a release leaves another segment queued behind it.
  assign start_evt = (cnt_next != 3'd0) && ((fill_cnt == 3'd0) || rd_pop);

  assign widx = MEM_AW'(wbank) * MEM_AW'(SEG_DEPTH) + MEM_AW'(waddr);
  assign ridx = MEM_AW'(rbank) * MEM_AW'(SEG_DEPTH) + MEM_AW'(rd_addr);

  // Storage is deliberately left out of reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[widx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbank     <= 2'd0;
      rbank     <= 2'd0;
      waddr     <= '0;
      full      <= '0;
      fill_cnt  <= 3'd0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dsi_start <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (seg_done) begin
          waddr <= '0;
          wbank <= next_bank(wbank);
        end else begin
          waddr <= waddr + 1'b1;
        end
      end
      if (wr_en && !wfull) begin
        overflow <= overflow;
      end else if (wr_en) begin
        overflow <= 1'b1;
      end

      if (rd_pop) begin
        rbank <= next_bank(rbank);
      end else if (rd_done) begin
        underflow <= 1'b1;
      end

      // Reads of a bank that is not full return whatever the storage holds.
      if (rd_en && rd_in_range) begin
        rd_data <= mem[ridx];
      end

      full      <= full_next;
      fill_cnt  <= cnt_next;
      dsi_start <= start_evt;
    end
  end

  assign seg_ready = (fill_cnt != 3'd0);
  assign rd_bank   = rbank;

endmodule

// File: doc/dsi_segment_buffer.md
DSI_SEGMENT_BUFFER -- requirements
Module: dsi_segment_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter SEG_DEPTH, default 1920 (12'h780), pixels per segment (240 x 8).
REQ-003 SHALL have parameter NUM_BANKS, default 2, legal 2..4, number of segment banks in the ring.
REQ-004 SHALL have parameter ADDR_W, default 12, pixel address width; SEG_DEPTH <= 2^ADDR_W.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_en  in  1  write strobe for incoming pixel.
REQ-008 SHALL have port wr_data  in  DATA_W  incoming pixel.
REQ-009 SHALL have port wr_ready  out  1  current write bank not full.
REQ-010 SHALL have port rd_en  in  1  read strobe.
REQ-011 SHALL have port rd_addr  in  ADDR_W  pixel address within current read bank.
REQ-012 SHALL have port rd_data  out  DATA_W  registered read data.
REQ-013 SHALL have port rd_done  in  1  one-cycle pulse: consumer finished current read bank.
REQ-014 SHALL have port seg_ready  out  1  at least one full bank held.
REQ-015 SHALL have port dsi_start  out  1  one-cycle pulse: start DSI transfer of the head segment.
REQ-016 SHALL have port rd_bank  out  2  index of bank being read.
REQ-017 SHALL have port fill_cnt  out  3  number of full banks, 0..NUM_BANKS.
REQ-018 SHALL have port overflow  out  1  sticky: write dropped.
REQ-019 SHALL have port underflow  out  1  sticky: rd_done with no full bank.

Function
REQ-020 SHALL hold NUM_BANKS x SEG_DEPTH x DATA_W storage, write pointer wbank, write address waddr, read pointer rbank, per-bank full flags.
REQ-021 wr_ready SHALL equal NOT full[wbank], combinationally.
REQ-022 wr_en AND wr_ready SHALL write wr_data at (wbank, waddr) and increment waddr.
REQ-023 Accepted write at waddr == SEG_DEPTH-1 SHALL set full[wbank], clear waddr to 0, and advance wbank modulo NUM_BANKS, all on that edge.
REQ-024 wr_en with wr_ready low SHALL drop the pixel, leave waddr unchanged, and set overflow.
REQ-025 rd_en SHALL load rd_data with storage at (rbank, rd_addr) on the next edge (1-cycle latency); without rd_en rd_data SHALL hold.
REQ-026 rd_en with rd_addr >= SEG_DEPTH SHALL leave rd_data unchanged.
REQ-027 rd_en while full[rbank] is low SHALL still read (stale data), with no flag.
REQ-028 rd_done with full[rbank] high SHALL clear full[rbank] and advance rbank modulo NUM_BANKS.
REQ-029 rd_done with full[rbank] low SHALL change no pointer and set underflow.
REQ-030 Segment completion (REQ-023) and valid rd_done (REQ-028) in the same cycle SHALL both take effect; fill_cnt net unchanged.
REQ-031 fill_cnt SHALL be a registered count of set full flags; seg_ready = (fill_cnt != 0).
REQ-032 dsi_start SHALL pulse one cycle after the edge where fill_cnt goes 0 -> nonzero.
REQ-033 dsi_start SHALL also pulse one cycle after a valid rd_done that leaves fill_cnt >= 1 (next segment queued).
REQ-034 A write to the bank being read SHALL be impossible by construction (write requires not full, read bank is full while valid).
REQ-035 rd_bank SHALL equal rbank, zero-extended to 2 bits.

Reset
REQ-036 reset SHALL set wbank, rbank, waddr, full flags, fill_cnt, rd_data, overflow, underflow to 0; wr_ready to 1; seg_ready and dsi_start to 0.
REQ-037 reset SHALL NOT clear storage contents.
REQ-038 reset mid-segment SHALL discard the partial segment; the next accepted write lands at bank 0, address 0.
REQ-039 reset SHALL have priority over all other inputs in the same cycle.

Verification
REQ-040 Write 1920 pixels data=index, NUM_BANKS=2 -> fill_cnt=1, seg_ready=1, one dsi_start pulse, wbank=1; rd_en rd_addr=12'h77F -> rd_data=16'h077F next cycle.
REQ-041 Fill both banks without rd_done, then 1 more write -> wr_ready=0, pixel dropped, overflow=1, fill_cnt=2.
REQ-042 Two banks full, rd_done -> rd_bank=1, fill_cnt=1, dsi_start pulse next cycle; second rd_done -> fill_cnt=0, no dsi_start.
REQ-043 Last pixel of bank 1 written same cycle as rd_done of bank 0 -> fill_cnt stays 1, rd_bank=1, wbank=0.
REQ-044 rd_done at reset state -> underflow=1, rd_bank=0, fill_cnt=0.
REQ-045 NUM_BANKS=3, reset asserted after 1000 pixels of bank 1 -> all outputs per REQ-036; next 1920 writes fill bank 0.
